// File: rtl/wb_mem_reader_pkg.sv
// Shared definitions for the Wishbone block-read master: FSM encoding,
// default ack timeout and the all-bytes select pattern.
package wb_mem_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int         TIMEOUT_DEFAULT = 1024;
   localparam logic [3:0] SEL_ALL         = 4'hF;

endpackage

// File: rtl/wb_mem_reader.sv
// Wishbone read master: fetches i_count consecutive words from i_address,
// presenting each on o_data/o_data_valid until the consumer accepts it.
module wb_mem_reader
   import wb_mem_reader_pkg::*;
#(
   parameter int TIMEOUT     = TIMEOUT_DEFAULT,
   parameter int COUNT_WIDTH = 24
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_start,
   input  logic [31:0]            i_address,
   input  logic [COUNT_WIDTH-1:0] i_count,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_error,
   output logic                   o_mem_we,
   output logic                   o_mem_stb,
   output logic                   o_mem_cyc,
   output logic [3:0]             o_mem_sel,
   output logic [31:0]            o_mem_adr,
   output logic [31:0]            o_mem_dat,
   input  logic [31:0]            i_mem_dat,
   input  logic                   i_mem_ack,
   input  logic                   i_mem_int,
   output logic [31:0]            o_data,
   output logic                   o_data_valid,
   input  logic                   i_data_ready
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);

   state_t                 state_q, state_d;
   logic [31:0]            addr_q, addr_d;
   logic [COUNT_WIDTH-1:0] rem_q, rem_d;
   logic [TMO_W-1:0]       tmo_q, tmo_d;
   logic [31:0]            data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   error_q, error_d;
   logic                   zdone_q, zdone_d;

   logic unused_mem_int;
   assign unused_mem_int = i_mem_int;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         tmo_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         error_q <= 1'b0;
         zdone_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         tmo_q   <= tmo_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         error_q <= error_d;
         zdone_q <= zdone_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      tmo_d   = tmo_q;
      data_d  = data_q;
      valid_d = valid_q;
      error_d = error_q;
      zdone_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               if (i_count != '0) begin
                  addr_d  = i_address;
                  rem_d   = i_count;
                  error_d = 1'b0;
                  tmo_d   = '0;
                  state_d = ST_REQ;
               end else begin
                  // Zero-length request: report completion without touching the bus
                  zdone_d = 1'b1;
               end
            end
         end
         ST_REQ: begin
            if (i_mem_ack) begin
               data_d  = i_mem_dat;
               valid_d = 1'b1;
               addr_d  = addr_q + 32'd1;
               rem_d   = rem_q - COUNT_WIDTH'(1);
               state_d = ST_HOLD;
            end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
               error_d = 1'b1;
               state_d = ST_DONE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         ST_HOLD: begin
            if (i_data_ready) begin
               valid_d = 1'b0;
               tmo_d   = '0;
               state_d = (rem_q == '0) ? ST_DONE : ST_REQ;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Bus strobes decode straight from state so they drop on the ack edge
   assign o_mem_cyc    = (state_q == ST_REQ);
   assign o_mem_stb    = (state_q == ST_REQ);
   assign o_mem_we     = 1'b0;
   assign o_mem_sel    = (state_q == ST_REQ) ? SEL_ALL : 4'h0;
   assign o_mem_adr    = addr_q;
   assign o_mem_dat    = 32'h0;
   assign o_busy       = (state_q != ST_IDLE);
   assign o_done       = (state_q == ST_DONE) | zdone_q;
   assign o_error      = error_q;
   assign o_data       = data_q;
   assign o_data_valid = valid_q;

endmodule
